// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the tiled convolution engine.
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, WRITE} state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // One COMPUTE cycle per (tile pair, row, col, i, j) iteration.
   function automatic int compute_cycles(input int m, input int n, input int tm, input int tn,
                                          input int r, input int c, input int k);
      return ceil_div(m, tm) * ceil_div(n, tn) * r * c * k * k;
   endfunction

endpackage

// File: rtl/cnn_mac_lane.sv
// One output-map lane: Tn-wide multiply, ordered sum from n=ti, then accumulate.
module cnn_mac_lane
   import cnn_pkg::*;
#(
   parameter int Tn_p = 1
) (
   input  logic            en,
   input  logic [Tn_p-1:0] n_mask,
   input  shortreal        w [Tn_p],
   input  shortreal        x [Tn_p],
   input  shortreal        acc,
   output shortreal        acc_nxt
);

   shortreal sum;

   always_comb begin
      sum = w[0] * x[0];
      for (int k = 1; k < Tn_p; k++)
         if (n_mask[k]) sum = sum + w[k] * x[k];
      acc_nxt = (en && n_mask[0]) ? acc + sum : acc;
   end

endmodule

// File: rtl/cnn_conv_engine.sv
// Tiled convolution layer: snapshot inputs, walk the Tm x Tn tile loop nest, publish fm_o at the end.
module cnn_conv_engine
   import cnn_pkg::*;
#(
   parameter int N_p  = 1,
   parameter int M_p  = 1,
   parameter int K_p  = 1,
   parameter int R_p  = 4,
   parameter int C_p  = 4,
   parameter int S_p  = 1,
   parameter int Tn_p = 1,
   parameter int Tm_p = 1
) (
   input  shortreal fm_i      [N_p][R_p][C_p],
   input  shortreal weights_i [M_p][N_p][K_p][K_p],
   input  logic     clk_i,
   input  logic     reset_i,
   input  logic     valid_i,
   output shortreal fm_o      [M_p][R_p][C_p]
);

   localparam int CYCLES = compute_cycles(M_p, N_p, Tm_p, Tn_p, R_p, C_p, K_p);

   state_t   state;
   int       cyc, to_c, ti_c, row_c, col_c, i_c, j_c;
   shortreal x_r [N_p][R_p][C_p];
   shortreal w_r [M_p][N_p][K_p][K_p];
   shortreal acc [M_p][R_p][C_p];

   shortreal        xt      [Tn_p];
   shortreal        wt      [Tm_p][Tn_p];
   shortreal        acc_cur [Tm_p];
   shortreal        acc_nxt [Tm_p];
   logic [Tm_p-1:0] lane_en;
   logic [Tn_p-1:0] n_mask;

   // Taps are muxed by full compare so out-of-range (padding) positions fall through to 0.0.
   always_comb begin
      for (int k = 0; k < Tn_p; k++) begin
         n_mask[k] = (ti_c + k) < N_p;
         xt[k]     = 0.0;
         for (int n = 0; n < N_p; n++)
            for (int r = 0; r < R_p; r++)
               for (int c = 0; c < C_p; c++)
                  if (n == ti_c + k && r == row_c * S_p + i_c && c == col_c * S_p + j_c)
                     xt[k] = x_r[n][r][c];
      end
      for (int l = 0; l < Tm_p; l++) begin
         lane_en[l] = (state == COMPUTE) && ((to_c + l) < M_p);
         acc_cur[l] = 0.0;
         for (int m = 0; m < M_p; m++)
            for (int r = 0; r < R_p; r++)
               for (int c = 0; c < C_p; c++)
                  if (m == to_c + l && r == row_c && c == col_c) acc_cur[l] = acc[m][r][c];
         for (int k = 0; k < Tn_p; k++) begin
            wt[l][k] = 0.0;
            for (int m = 0; m < M_p; m++)
               for (int n = 0; n < N_p; n++)
                  for (int a = 0; a < K_p; a++)
                     for (int b = 0; b < K_p; b++)
                        if (m == to_c + l && n == ti_c + k && a == i_c && b == j_c)
                           wt[l][k] = w_r[m][n][a][b];
         end
      end
   end

   for (genvar l = 0; l < Tm_p; l++) begin : g_lane
      cnn_mac_lane #(.Tn_p(Tn_p)) u_lane (
         .en      (lane_en[l]),
         .n_mask  (n_mask),
         .w       (wt[l]),
         .x       (xt),
         .acc     (acc_cur[l]),
         .acc_nxt (acc_nxt[l])
      );
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         cyc   <= 0;
         to_c  <= 0;
         ti_c  <= 0;
         row_c <= 0;
         col_c <= 0;
         i_c   <= 0;
         j_c   <= 0;
         for (int m = 0; m < M_p; m++)
            for (int r = 0; r < R_p; r++)
               for (int c = 0; c < C_p; c++) begin
                  fm_o[m][r][c] <= 0.0;
                  acc[m][r][c]  <= 0.0;
               end
      end else begin
         case (state)
            IDLE: if (valid_i) state <= LOAD;
            LOAD: begin
               x_r   <= fm_i;
               w_r   <= weights_i;
               cyc   <= 0;
               to_c  <= 0;
               ti_c  <= 0;
               row_c <= 0;
               col_c <= 0;
               i_c   <= 0;
               j_c   <= 0;
               for (int m = 0; m < M_p; m++)
                  for (int r = 0; r < R_p; r++)
                     for (int c = 0; c < C_p; c++) acc[m][r][c] <= 0.0;
               state <= COMPUTE;
            end
            COMPUTE: begin
               for (int l = 0; l < Tm_p; l++)
                  for (int m = 0; m < M_p; m++)
                     for (int r = 0; r < R_p; r++)
                        for (int c = 0; c < C_p; c++)
                           if (lane_en[l] && m == to_c + l && r == row_c && c == col_c)
                              acc[m][r][c] <= acc_nxt[l];
               // Loop nest, innermost first: j, i, col, row, ti, to.
               cyc <= cyc + 1;
               if (j_c == K_p - 1) begin
                  j_c <= 0;
                  if (i_c == K_p - 1) begin
                     i_c <= 0;
                     if (col_c == C_p - 1) begin
                        col_c <= 0;
                        if (row_c == R_p - 1) begin
                           row_c <= 0;
                           if (ti_c + Tn_p >= N_p) begin
                              ti_c <= 0;
                              to_c <= to_c + Tm_p;
                           end else ti_c <= ti_c + Tn_p;
                        end else row_c <= row_c + 1;
                     end else col_c <= col_c + 1;
                  end else i_c <= i_c + 1;
               end else j_c <= j_c + 1;
               if (cyc == CYCLES - 1) state <= WRITE;
            end
            WRITE: begin
               fm_o  <= acc;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboarded bench: three engine configurations driven in turn against a direct-convolution model.
module tb_cnn_conv_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
   logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

   shortreal fm0 [1][4][4];
   shortreal w0  [1][1][1][1];
   shortreal out0[1][4][4];
   shortreal fm1 [2][4][4];
   shortreal w1  [3][2][3][3];
   shortreal out1[3][4][4];
   shortreal fm2 [1][4][4];
   shortreal w2  [1][1][1][1];
   shortreal out2[1][4][4];

   int  checks = 0;
   int  errors = 0;
   real exp_q[$];
   int  lat;

   cnn_conv_engine u_d0 (
      .fm_i(fm0), .weights_i(w0), .clk_i(clk), .reset_i(r0), .valid_i(v0), .fm_o(out0));

   cnn_conv_engine #(.N_p(2), .M_p(3), .K_p(3), .Tn_p(2), .Tm_p(2)) u_d1 (
      .fm_i(fm1), .weights_i(w1), .clk_i(clk), .reset_i(r1), .valid_i(v1), .fm_o(out1));

   cnn_conv_engine #(.S_p(2)) u_d2 (
      .fm_i(fm2), .weights_i(w2), .clk_i(clk), .reset_i(r2), .valid_i(v2), .fm_o(out2));

   task automatic chk(input string tag, input real got, input real exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %f expected %f", tag, got, exp);
      end
   endtask

   task automatic set_v(input int which, input logic val);
      case (which)
         0: v0 = val;
         1: v1 = val;
         default: v2 = val;
      endcase
   endtask

   task automatic set_r(input int which, input logic val);
      case (which)
         0: r0 = val;
         1: r1 = val;
         default: r2 = val;
      endcase
   endtask

   task automatic pulse(input int which);
      @(negedge clk); set_v(which, 1'b1);
      @(negedge clk); set_v(which, 1'b0);
   endtask

   task automatic do_reset(input int which);
      @(negedge clk); set_r(which, 1'b1);
      @(negedge clk); set_r(which, 1'b0);
   endtask

   task automatic load_stim(input int which, input bit ramp, input real fv, input real wv);
      case (which)
         0: begin
            foreach (fm0[n, r, c]) fm0[n][r][c] = ramp ? shortreal'(r * 4 + c) : shortreal'(fv);
            foreach (w0[m, n, i, j]) w0[m][n][i][j] = shortreal'(wv);
         end
         1: begin
            foreach (fm1[n, r, c]) fm1[n][r][c] = ramp ? shortreal'(r * 4 + c) : shortreal'(fv);
            foreach (w1[m, n, i, j]) w1[m][n][i][j] = shortreal'(wv);
         end
         default: begin
            foreach (fm2[n, r, c]) fm2[n][r][c] = ramp ? shortreal'(r * 4 + c) : shortreal'(fv);
            foreach (w2[m, n, i, j]) w2[m][n][i][j] = shortreal'(wv);
         end
      endcase
   endtask

   // Direct convolution with zero padding at the bottom/right edges.
   task automatic push_model(input int which);
      real x[2][4][4];
      real w[3][2][3][3];
      int  mm, nn, kk, ss, rr, cc;
      shortreal y;
      foreach (x[n, r, c]) x[n][r][c] = 0.0;
      foreach (w[m, n, i, j]) w[m][n][i][j] = 0.0;
      case (which)
         0: begin
            mm = 1; nn = 1; kk = 1; ss = 1;
            foreach (fm0[n, r, c]) x[n][r][c] = fm0[n][r][c];
            foreach (w0[m, n, i, j]) w[m][n][i][j] = w0[m][n][i][j];
         end
         1: begin
            mm = 3; nn = 2; kk = 3; ss = 1;
            foreach (fm1[n, r, c]) x[n][r][c] = fm1[n][r][c];
            foreach (w1[m, n, i, j]) w[m][n][i][j] = w1[m][n][i][j];
         end
         default: begin
            mm = 1; nn = 1; kk = 1; ss = 2;
            foreach (fm2[n, r, c]) x[n][r][c] = fm2[n][r][c];
            foreach (w2[m, n, i, j]) w[m][n][i][j] = w2[m][n][i][j];
         end
      endcase
      for (int m = 0; m < mm; m++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               y = 0.0;
               for (int n = 0; n < nn; n++)
                  for (int i = 0; i < kk; i++)
                     for (int j = 0; j < kk; j++) begin
                        rr = r * ss + i;
                        cc = c * ss + j;
                        if (rr < 4 && cc < 4) y = y + shortreal'(w[m][n][i][j] * x[n][rr][cc]);
                     end
               exp_q.push_back(real'(y));
            end
   endtask

   function automatic bit nz(input int which);
      bit f = 1'b0;
      case (which)
         0: foreach (out0[m, r, c]) if (out0[m][r][c] != 0.0) f = 1'b1;
         1: foreach (out1[m, r, c]) if (out1[m][r][c] != 0.0) f = 1'b1;
         default: foreach (out2[m, r, c]) if (out2[m][r][c] != 0.0) f = 1'b1;
      endcase
      return f;
   endfunction

   // Counts negedges until any output goes non-zero, bounded by budget.
   task automatic wait_out(input int which, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!nz(which) && n < budget);
   endtask

   task automatic cmp_out(input int which, input string tag);
      real e;
      case (which)
         0: foreach (out0[m, r, c]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1.0e9;
            chk($sformatf("%s[%0d][%0d][%0d]", tag, m, r, c), out0[m][r][c], e);
         end
         1: foreach (out1[m, r, c]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1.0e9;
            chk($sformatf("%s[%0d][%0d][%0d]", tag, m, r, c), out1[m][r][c], e);
         end
         default: foreach (out2[m, r, c]) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : -1.0e9;
            chk($sformatf("%s[%0d][%0d][%0d]", tag, m, r, c), out2[m][r][c], e);
         end
      endcase
   endtask

   initial begin
      load_stim(0, 1'b0, 0.0, 0.0);
      load_stim(1, 1'b0, 0.0, 0.0);
      load_stim(2, 1'b0, 0.0, 0.0);
      repeat (3) @(negedge clk);
      r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
      @(negedge clk);
      foreach (out0[m, r, c]) chk("rst_out0", out0[m][r][c], 0.0);
      chk("rst_out1_2_3_3", out1[2][3][3], 0.0);

      // Constant maps, unit weight.
      load_stim(0, 1'b0, 0.5, 1.0);
      push_model(0);
      pulse(0);
      wait_out(0, 60, lat);
      chk("lat_const", lat, 18);
      cmp_out(0, "const");

      // Ramp maps, weight 2.
      do_reset(0);
      load_stim(0, 1'b1, 0.0, 2.0);
      push_model(0);
      pulse(0);
      wait_out(0, 60, lat);
      chk("lat_ramp", lat, 18);
      chk("ramp_3_3", out0[0][3][3], 30.0);
      cmp_out(0, "ramp");

      // Tiled 3x2 maps, 3x3 kernel with edge padding.
      load_stim(1, 1'b0, 1.0, 1.0);
      push_model(1);
      pulse(1);
      wait_out(1, 400, lat);
      chk("lat_tile", lat, 290);
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("tile_%0d_0_0", m), out1[m][0][0], 18.0);
         chk($sformatf("tile_%0d_3_3", m), out1[m][3][3], 2.0);
      end
      cmp_out(1, "tile");

      // Stride 2: taps beyond the map read zero.
      load_stim(2, 1'b1, 0.0, 1.0);
      push_model(2);
      pulse(2);
      wait_out(2, 60, lat);
      chk("lat_stride", lat, 18);
      chk("stride_1_1", out2[0][1][1], 10.0);
      chk("stride_2_0", out2[0][2][0], 0.0);
      cmp_out(2, "stride");

      // Reset in the middle of COMPUTE discards the run and clears fm_o.
      load_stim(0, 1'b0, 0.5, 1.0);
      pulse(0);
      repeat (8) @(negedge clk);
      r0 = 1'b1;
      @(negedge clk);
      r0 = 1'b0;
      chk("midrst_3_3", out0[0][3][3], 0.0);
      chk("midrst_1_1", out0[0][1][1], 0.0);
      load_stim(0, 1'b0, 0.25, 1.0);
      push_model(0);
      pulse(0);
      wait_out(0, 60, lat);
      chk("lat_after_rst", lat, 18);
      cmp_out(0, "after_rst");

      // Inputs change after LOAD and a second valid arrives mid-COMPUTE: both ignored.
      do_reset(0);
      load_stim(0, 1'b1, 0.0, 1.0);
      push_model(0);
      pulse(0);
      @(negedge clk);
      load_stim(0, 1'b0, 7.0, 3.0);
      repeat (3) @(negedge clk);
      v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      wait_out(0, 60, lat);
      chk("lat_dup_valid", lat + 5, 18);
      cmp_out(0, "dup_valid");
      repeat (30) @(negedge clk);
      chk("no_requeue_3_3", out0[0][3][3], 15.0);
      chk("no_requeue_0_1", out0[0][0][1], 1.0);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
